// File: rtl/computie_bus_pkg.sv
// Shared constants for the computie serial bus loader: ASCII codes, loader
// state encodings and bus request record field offsets.
package computie_bus_pkg;

  localparam logic [7:0] ASCII_CR     = 8'h0D;
  localparam logic [7:0] ASCII_LF     = 8'h0A;
  localparam logic [7:0] ASCII_SPACE  = 8'h20;
  localparam logic [7:0] ASCII_COLON  = 8'h3A;
  localparam logic [7:0] ASCII_R      = 8'h52;
  localparam logic [7:0] ASCII_R_LC   = 8'h72;
  localparam logic [7:0] ASCII_W      = 8'h57;
  localparam logic [7:0] ASCII_W_LC   = 8'h77;

  typedef enum logic [2:0] {
    LS_IDLE    = 3'd0,
    LS_ADDR    = 3'd1,
    LS_DATA    = 3'd2,
    LS_EMIT    = 3'd3,
    LS_DISCARD = 3'd4
  } loader_state_e;

  // Record layout is {mod, addr, data}; the read flag is the lowest mod bit.
  function automatic int rw_bit(input int bitwidth);
    return bitwidth * 2;
  endfunction

  function automatic int addr_lsb(input int bitwidth);
    return bitwidth;
  endfunction

endpackage

// File: rtl/computie_ascii_hex_decode.sv
// Combinational ASCII hex digit decoder: '0'-'9', 'A'-'F', 'a'-'f' -> nibble.
// Any other byte reports is_hex=0 with a zero nibble.
module computie_ascii_hex_decode (
  input  logic [7:0] ascii,
  output logic       is_hex,
  output logic [3:0] nibble
);

  always_comb begin
    is_hex = 1'b0;
    nibble = 4'h0;
    if (ascii >= 8'h30 && ascii <= 8'h39) begin
      is_hex = 1'b1;
      nibble = ascii[3:0];
    end else if ((ascii >= 8'h41 && ascii <= 8'h46) ||
                 (ascii >= 8'h61 && ascii <= 8'h66)) begin
      // Letters A-F/a-f carry 1..6 in their low nibble.
      is_hex = 1'b1;
      nibble = ascii[3:0] + 4'd9;
    end
  end

endmodule

// File: rtl/computie_bus_loader.sv
// Parses 'R<addr>' / 'W<addr>:<data>' ASCII lines into bus request records.
// Optional build macro COMPUTIE_BUS_LOADER_ERROR_COUNT_EN enables error_count.
module computie_bus_loader
  import computie_bus_pkg::*;
#(
  parameter int BITWIDTH = 32,
  parameter int MODWIDTH = 1
) (
  input  logic                           comm_clock,
  input  logic                           comm_reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [7:0]                     in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [BITWIDTH*2+MODWIDTH-1:0] out_data,
  output logic                           parse_error,
  output logic [7:0]                     error_count
);

  localparam int NDIG   = BITWIDTH / 4;
  localparam int CW     = $clog2(NDIG) + 1;
  localparam int RW_BIT = rw_bit(BITWIDTH);
  localparam int A_LSB  = addr_lsb(BITWIDTH);
  localparam logic [CW-1:0] NDIG_C = CW'(NDIG);

  loader_state_e         state;
  loader_state_e         nxt_state;
  logic                  rd;
  logic [CW-1:0]         count;
  logic [BITWIDTH-1:0]   addr;
  logic [BITWIDTH-1:0]   data;
  logic                  is_hex;
  logic [3:0]            nibble;
  logic                  accept;
  logic                  is_term;
  logic                  err_now;
  logic                  start_line;
  logic                  start_rd;
  logic                  shift_addr;
  logic                  shift_data;
  logic                  clr_count;
  logic                  emit;
  logic [BITWIDTH*2+MODWIDTH-1:0] record;

  computie_ascii_hex_decode u_hex (
    .ascii  (in_data),
    .is_hex (is_hex),
    .nibble (nibble)
  );

  assign in_ready = (state != LS_EMIT);
  assign accept   = in_valid && in_ready;
  assign is_term  = (in_data == ASCII_CR) || (in_data == ASCII_LF);

  always_comb begin
    nxt_state  = state;
    err_now    = 1'b0;
    start_line = 1'b0;
    start_rd   = 1'b0;
    shift_addr = 1'b0;
    shift_data = 1'b0;
    clr_count  = 1'b0;
    emit       = 1'b0;
    case (state)
      LS_IDLE: if (accept) begin
        if (in_data == ASCII_SPACE || is_term) begin
          nxt_state = LS_IDLE;
        end else if (in_data == ASCII_R || in_data == ASCII_R_LC) begin
          start_line = 1'b1;
          start_rd   = 1'b1;
          nxt_state  = LS_ADDR;
        end else if (in_data == ASCII_W || in_data == ASCII_W_LC) begin
          start_line = 1'b1;
          nxt_state  = LS_ADDR;
        end else begin
          err_now = 1'b1;
        end
      end
      LS_ADDR: if (accept) begin
        if (is_hex) begin
          if (count != NDIG_C) shift_addr = 1'b1;
          else                 err_now    = 1'b1;
        end else if (in_data == ASCII_COLON && count != '0 && !rd) begin
          clr_count = 1'b1;
          nxt_state = LS_DATA;
        end else if (is_term && count != '0 && rd) begin
          emit = 1'b1;
        end else begin
          err_now = 1'b1;
        end
      end
      LS_DATA: if (accept) begin
        if (is_hex) begin
          if (count != NDIG_C) shift_data = 1'b1;
          else                 err_now    = 1'b1;
        end else if (is_term && count != '0) begin
          emit = 1'b1;
        end else begin
          err_now = 1'b1;
        end
      end
      LS_EMIT: if (out_ready) nxt_state = LS_IDLE;
      LS_DISCARD: if (accept && is_term) nxt_state = LS_IDLE;
      default: nxt_state = LS_IDLE;
    endcase
    if (emit)    nxt_state = LS_EMIT;
    if (err_now) nxt_state = is_term ? LS_IDLE : LS_DISCARD;
  end

  always_comb begin
    record                        = '0;
    record[RW_BIT]                = rd;
    record[A_LSB +: BITWIDTH]     = addr;
    record[BITWIDTH-1:0]          = data;
  end

  always_ff @(posedge comm_clock or posedge comm_reset) begin
    if (comm_reset) begin
      state       <= LS_IDLE;
      rd          <= 1'b0;
      count       <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      parse_error <= 1'b0;
    end else begin
      state       <= nxt_state;
      parse_error <= err_now;
      if (start_line) rd <= start_rd;
      if (start_line || clr_count)       count <= '0;
      else if (shift_addr || shift_data) count <= count + CW'(1);
      if (emit) begin
        out_valid <= 1'b1;
        out_data  <= record;
      end else if (state == LS_EMIT && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Field accumulators are cleared at each line start, so they need no reset.
  always_ff @(posedge comm_clock) begin
    if (start_line) begin
      addr <= '0;
      data <= '0;
    end else begin
      if (shift_addr) addr <= {addr[BITWIDTH-5:0], nibble};
      if (shift_data) data <= {data[BITWIDTH-5:0], nibble};
    end
  end

`ifdef COMPUTIE_BUS_LOADER_ERROR_COUNT_EN
  logic [7:0] err_cnt;

  always_ff @(posedge comm_clock or posedge comm_reset) begin
    if (comm_reset)                    err_cnt <= 8'h00;
    else if (err_now && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
  end

  assign error_count = err_cnt;
`else
  assign error_count = 8'h00;
`endif

endmodule

// File: tb/tb_computie_bus_loader.sv
// Directed self-checking bench for computie_bus_loader (BITWIDTH=32, MODWIDTH=1).
module tb_computie_bus_loader;

  logic        comm_clock = 1'b0;
  logic        comm_reset;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [64:0] out_data;
  logic        parse_error;
  logic [7:0]  error_count;

  int n_assert = 0;
  int n_fail   = 0;
  int pe_cnt   = 0;
  int rec_n    = 0;
  int rd_idx   = 0;
  int pe_base;
  logic [64:0] rec_mem [0:63];

  computie_bus_loader #(.BITWIDTH(32), .MODWIDTH(1)) dut (
    .comm_clock  (comm_clock),
    .comm_reset  (comm_reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .parse_error (parse_error),
    .error_count (error_count)
  );

  always #5 comm_clock = ~comm_clock;

  always @(posedge comm_clock) begin
    if (out_valid && out_ready && rec_n < 64) begin
      rec_mem[rec_n] = out_data;
      rec_n = rec_n + 1;
    end
    if (parse_error) pe_cnt = pe_cnt + 1;
  end

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(negedge comm_clock);
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", {64'd0, in_ready}, 65'd1);
    in_valid = 1'b1;
    in_data  = b;
    @(negedge comm_clock);
    in_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic next_rec(input string tag, input logic [64:0] exp);
    if (rd_idx < rec_n) begin
      chk(tag, rec_mem[rd_idx], exp);
      rd_idx++;
    end else begin
      chk({tag, "_missing"}, {33'd0, 32'(rec_n)}, {33'd0, 32'(rd_idx + 1)});
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge comm_clock);
  endtask

  logic [7:0] exp_ec;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    comm_reset = 1'b1;
    in_valid   = 1'b0;
    in_data    = 8'h00;
    out_ready  = 1'b1;
    idle(3);
    chk("rst_out_valid", {64'd0, out_valid}, 65'd0);
    chk("rst_out_data", out_data, 65'd0);
    chk("rst_parse_error", {64'd0, parse_error}, 65'd0);
    chk("rst_error_count", {57'd0, error_count}, 65'd0);
    chk("rst_in_ready", {64'd0, in_ready}, 65'd1);
    comm_reset = 1'b0;
    idle(2);

    // 1: full-width write with uppercase hex
    pe_base = pe_cnt;
    send_str("W0000ABCD:12345678\n");
    idle(3);
    next_rec("t1_rec", {1'b0, 32'h0000ABCD, 32'h12345678});
    chk("t1_nerr", {33'd0, 32'(pe_cnt - pe_base)}, 65'd0);

    // 2: read held by out_ready=0 for 5 cycles
    out_ready = 1'b0;
    send_str("R00FF0010\n");
    for (int i = 0; i < 5; i++) begin
      chk("t2_valid", {64'd0, out_valid}, 65'd1);
      chk("t2_in_ready", {64'd0, in_ready}, 65'd0);
      chk("t2_data", out_data, {1'b1, 32'h00FF0010, 32'h0});
      @(negedge comm_clock);
    end
    out_ready = 1'b1;
    @(negedge comm_clock);
    chk("t2_valid_drop", {64'd0, out_valid}, 65'd0);
    chk("t2_in_ready_back", {64'd0, in_ready}, 65'd1);
    next_rec("t2_rec", {1'b1, 32'h00FF0010, 32'h0});

    // 3: lowercase command and digit, CR terminator
    send_str("r1f\r");
    idle(3);
    next_rec("t3_rec", {1'b1, 32'h0000001F, 32'h0});

    // 4: bad line discarded, then short write
    pe_base = pe_cnt;
    send_str("WXYZ\nW1:2\n");
    idle(3);
    chk("t4_nerr", {33'd0, 32'(pe_cnt - pe_base)}, 65'd1);
    next_rec("t4_rec", {1'b0, 32'h1, 32'h2});
`ifdef COMPUTIE_BUS_LOADER_ERROR_COUNT_EN
    exp_ec = 8'd1;
`else
    exp_ec = 8'd0;
`endif
    chk("t4_error_count", {57'd0, error_count}, {57'd0, exp_ec});

    // 5: ninth address digit overflows; empty read address
    pe_base = pe_cnt;
    send_str("W123456789:0\n");
    idle(3);
    chk("t5_nerr_a", {33'd0, 32'(pe_cnt - pe_base)}, 65'd1);
    chk("t5_norec", {33'd0, 32'(rec_n)}, {33'd0, 32'(rd_idx)});
    send_str("R\n");
    idle(3);
    chk("t5_nerr_b", {33'd0, 32'(pe_cnt - pe_base)}, 65'd2);
    chk("t5_norec_b", {33'd0, 32'(rec_n)}, {33'd0, 32'(rd_idx)});
`ifdef COMPUTIE_BUS_LOADER_ERROR_COUNT_EN
    exp_ec = 8'd3;
`else
    exp_ec = 8'd0;
`endif
    chk("t5_error_count", {57'd0, error_count}, {57'd0, exp_ec});

    // 6: reset mid-line drops the partial write
    send_str("W12");
    comm_reset = 1'b1;
    #1;
    chk("t6_rst_out_valid", {64'd0, out_valid}, 65'd0);
    chk("t6_rst_out_data", out_data, 65'd0);
    chk("t6_rst_in_ready", {64'd0, in_ready}, 65'd1);
    chk("t6_rst_error_count", {57'd0, error_count}, 65'd0);
    idle(2);
    chk("t6_rst_parse_error", {64'd0, parse_error}, 65'd0);
    comm_reset = 1'b0;
    idle(1);
    send_str("R5\n");
    idle(3);
    next_rec("t6_rec", {1'b1, 32'h5, 32'h0});
    chk("t6_total_recs", {33'd0, 32'(rec_n)}, 65'd5);

    // Colon with no address digits is rejected and the line discarded
    pe_base = pe_cnt;
    send_str("W:1\nWa:B\n");
    idle(3);
    chk("t7_nerr", {33'd0, 32'(pe_cnt - pe_base)}, 65'd1);
    next_rec("t7_rec", {1'b0, 32'hA, 32'hB});

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
